// File: rtl/stride_counter.sv
// Up/down stride counter with run-time step, inclusive limit, synchronous load and
// wrap / saturate / one-shot terminal handling. Defaults reproduce the odd-number sequence.
module stride_counter #(
  parameter int WIDTH = 11,
  parameter int START = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             busy
);
  localparam logic [WIDTH-1:0] START_V      = WIDTH'(START);
  localparam logic [1:0]       MODE_SAT     = 2'b01;
  localparam logic [1:0]       MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;
  logic             terminal;
  logic             is_oneshot;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] clamp_v;
  logic [WIDTH-1:0] wrap_v;

  // The up test is done one bit wider so count+step cannot silently wrap below limit.
  function automatic logic hit_terminal(input logic [WIDTH-1:0] cnt,
                                        input logic [WIDTH-1:0] stp,
                                        input logic [WIDTH-1:0] lim,
                                        input logic             down);
    logic [WIDTH:0] sum;
    sum = {1'b0, cnt} + {1'b0, stp};
    if (down) return (cnt < stp);
    return (sum > {1'b0, lim});
  endfunction

  function automatic logic [WIDTH-1:0] clamp_target(input logic [WIDTH-1:0] lim,
                                                    input logic             down);
    return down ? '0 : lim;
  endfunction

  assign is_oneshot = (mode == MODE_ONESHOT);
  assign terminal   = hit_terminal(count_q, step, limit, dir);
  assign stepped    = dir ? (count_q - step) : (count_q + step);
  assign clamp_v    = clamp_target(limit, dir);
  assign wrap_v     = dir ? limit : START_V;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= START_V;
      tc_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!is_oneshot || load) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_RUN;
        S_RUN:   if (enable && terminal) state_d = S_DONE;
        S_DONE:  if (start) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    sat_d   = sat_q;
    if (load) begin
      count_d = load_value;
      sat_d   = 1'b0;
    end else if (is_oneshot && start && (state_q == S_DONE)) begin
      count_d = START_V;
    end else if (enable) begin
      case (mode)
        MODE_SAT: begin
          if (!sat_q) begin
            if (terminal) begin
              count_d = clamp_v;
              tc_d    = 1'b1;
              sat_d   = 1'b1;
            end else begin
              count_d = stepped;
            end
          end
        end
        MODE_ONESHOT: begin
          // Only RUN advances; IDLE (including the arming edge) and DONE hold.
          if (state_q == S_RUN) begin
            count_d = terminal ? clamp_v : stepped;
            tc_d    = terminal;
          end
        end
        default: begin
          count_d = terminal ? wrap_v : stepped;
          tc_d    = terminal;
        end
      endcase
    end
  end

  always_comb begin
    count = count_q;
    tc    = tc_q;
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_stride_counter.sv
// Bench for stride_counter: directed scenarios plus randomized traffic against a
// cycle-level behavioural model; a 4-bit instance covers the wide-adder terminal test.
module tb_stride_counter;
  localparam int W     = 11;
  localparam int START = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1, enable = 1'b0, load = 1'b0, dir = 1'b0, start = 1'b0;
  logic [W-1:0] load_value = '0, step = '0, limit = '0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] count;
  logic         tc, done, busy;

  logic         reset4 = 1'b1, enable4 = 1'b0, load4 = 1'b0, dir4 = 1'b0, start4 = 1'b0;
  logic [3:0]   load_value4 = '0, step4 = '0, limit4 = '0;
  logic [1:0]   mode4 = 2'b00;
  logic [3:0]   count4;
  logic         tc4, done4, busy4;

  int checks = 0;
  int errors = 0;

  int m_count = START;
  bit m_tc = 0, m_sat = 0, m_run = 0, m_fin = 0;

  stride_counter #(.WIDTH(W), .START(START)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .step(step), .limit(limit), .dir(dir), .mode(mode), .start(start),
    .count(count), .tc(tc), .done(done), .busy(busy)
  );

  stride_counter #(.WIDTH(4), .START(START)) dut4 (
    .clk(clk), .reset(reset4), .enable(enable4), .load(load4), .load_value(load_value4),
    .step(step4), .limit(limit4), .dir(dir4), .mode(mode4), .start(start4),
    .count(count4), .tc(tc4), .done(done4), .busy(busy4)
  );

  // Behavioural model of one clock edge, from the current inputs, in plain integers.
  task automatic model_tick();
    int  nxt;
    bit  term;
    bit  oneshot;
    m_tc = 0;
    if (reset) begin
      m_count = START; m_sat = 0; m_run = 0; m_fin = 0;
      return;
    end
    oneshot = (mode == 2'b10);
    if (!oneshot) begin
      m_run = 0; m_fin = 0;
    end
    if (load) begin
      m_count = int'(load_value); m_sat = 0; m_run = 0; m_fin = 0;
      return;
    end
    if (oneshot && start && !m_run) begin
      if (m_fin) m_count = START;
      m_run = 1; m_fin = 0;
      return;
    end
    if (!enable) return;
    nxt  = dir ? (m_count - int'(step)) : (m_count + int'(step));
    term = dir ? (nxt < 0) : (nxt > int'(limit));
    case (mode)
      2'b01: begin
        if (!m_sat) begin
          if (term) begin
            m_count = dir ? 0 : int'(limit); m_tc = 1; m_sat = 1;
          end else m_count = nxt;
        end
      end
      2'b10: begin
        if (m_run) begin
          if (term) begin
            m_count = dir ? 0 : int'(limit); m_tc = 1; m_run = 0; m_fin = 1;
          end else m_count = nxt;
        end
      end
      default: begin
        if (term) m_count = dir ? int'(limit) : START;
        else      m_count = nxt;
        m_tc = term;
      end
    endcase
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset4 = 1'b1;
    tick(); tick();
    checks++;
    if (count !== 11'd1 || tc !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d tc=%b done=%b busy=%b, want count=1 tc=0 done=0 busy=0",
               count, tc, done, busy);
    end
    checks++;
    if (count4 !== 4'd1 || tc4 !== 1'b0 || done4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4: count=%0d tc=%b done=%b busy=%b, want count=1 tc=0 done=0 busy=0",
               count4, tc4, done4, busy4);
    end
    reset4 = 1'b0;
  endtask

  task automatic test_defaults();
    reset = 1'b1; mode = 2'b00; dir = 1'b0; step = 11'd2; limit = 11'd2047; enable = 1'b1;
    tick();
    reset = 1'b0;
    for (int v = 3; v <= 2047; v += 2) begin
      tick();
      checks++;
      if (count !== 11'(v) || tc !== 1'b0) begin
        errors++;
        $display("FAIL defaults_seq: count=%0d tc=%b, want count=%0d tc=0", count, tc, v);
      end
    end
    tick();
    checks++;
    if (count !== 11'd1 || tc !== 1'b1) begin
      errors++;
      $display("FAIL defaults_wrap: count=%0d tc=%b, want count=1 tc=1", count, tc);
    end
    tick();
    checks++;
    if (count !== 11'd3 || tc !== 1'b0) begin
      errors++;
      $display("FAIL defaults_tc_pulse: count=%0d tc=%b, want count=3 tc=0", count, tc);
    end
  endtask

  task automatic test_saturate();
    int exp_c[8] = '{5, 9, 10, 10, 10, 10, 10, 10};
    bit exp_t[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    reset = 1'b1; enable = 1'b0; mode = 2'b01; dir = 1'b0; step = 11'd4; limit = 11'd10;
    tick();
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (count !== 11'(exp_c[i]) || tc !== exp_t[i]) begin
        errors++;
        $display("FAIL saturate[%0d]: count=%0d tc=%b, want count=%0d tc=%b",
                 i, count, tc, exp_c[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_load_priority();
    limit = 11'd200; step = 11'd2; load_value = 11'd100; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 11'd100 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_vs_enable: count=%0d tc=%b, want count=100 tc=0", count, tc);
    end
    tick();
    checks++;
    if (count !== 11'd102 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_clears_sat: count=%0d tc=%b, want count=102 tc=0", count, tc);
    end
  endtask

  task automatic test_oneshot_down();
    int exp_c[5] = '{5, 1, 0, 0, 0};
    bit exp_t[5] = '{0, 0, 1, 0, 0};
    bit exp_b[5] = '{1, 1, 0, 0, 0};
    bit exp_d[5] = '{0, 0, 1, 1, 1};
    mode = 2'b10; dir = 1'b1; step = 11'd4; limit = 11'd50;
    load_value = 11'd9; load = 1'b1; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    checks++;
    if (count !== 11'd9 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_idle_frozen: count=%0d busy=%b done=%b, want count=9 busy=0 done=0",
               count, busy, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (count !== 11'd9 || busy !== 1'b1 || done !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_arm: count=%0d busy=%b done=%b tc=%b, want count=9 busy=1 done=0 tc=0",
               count, busy, done, tc);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count !== 11'(exp_c[i]) || tc !== exp_t[i] || busy !== exp_b[i] || done !== exp_d[i]) begin
        errors++;
        $display("FAIL oneshot_run[%0d]: count=%0d tc=%b busy=%b done=%b, want %0d %b %b %b",
                 i, count, tc, busy, done, exp_c[i], exp_t[i], exp_b[i], exp_d[i]);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (count !== 11'd1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_restart: count=%0d busy=%b done=%b, want count=1 busy=1 done=0",
               count, busy, done);
    end
  endtask

  task automatic test_reset_in_run();
    mode = 2'b10; dir = 1'b0; step = 11'd4; limit = 11'd100;
    load_value = 11'd1; load = 1'b1; enable = 1'b0;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; enable = 1'b1;
    tick();
    checks++;
    if (count !== 11'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_before_reset: count=%0d busy=%b, want count=5 busy=1", count, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (count !== 11'd1 || tc !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_run: count=%0d tc=%b done=%b busy=%b, want 1 0 0 0",
               count, tc, done, busy);
    end
    tick();
    checks++;
    if (count !== 11'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: count=%0d busy=%b, want count=1 busy=0", count, busy);
    end
  endtask

  task automatic test_overflow_guard();
    mode4 = 2'b00; dir4 = 1'b0; limit4 = 4'd15; step4 = 4'd7;
    load_value4 = 4'd13; load4 = 1'b1; enable4 = 1'b0;
    tick();
    load4 = 1'b0; enable4 = 1'b1;
    checks++;
    if (count4 !== 4'd13) begin
      errors++;
      $display("FAIL overflow_load: count=%0d, want 13", count4);
    end
    tick();
    enable4 = 1'b0;
    checks++;
    if (count4 !== 4'd1 || tc4 !== 1'b1) begin
      errors++;
      $display("FAIL overflow_guard: count=%0d tc=%b, want count=1 tc=1", count4, tc4);
    end
  endtask

  task automatic test_random();
    reset = 1'b1; load = 1'b0; start = 1'b0; enable = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        mode  = 2'($urandom_range(0, 3));
        dir   = 1'($urandom_range(0, 1));
        limit = 11'($urandom_range(0, 2047));
        step  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                            : 11'($urandom_range(0, 40));
      end
      enable     = ($urandom_range(0, 3) != 0);
      load       = ($urandom_range(0, 39) == 0);
      load_value = 11'($urandom_range(0, 2047));
      start      = ($urandom_range(0, 9) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (count !== 11'(m_count) || tc !== m_tc || busy !== m_run || done !== m_fin) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d tc=%b busy=%b done=%b, want %0d %b %b %b",
                 i, count, tc, busy, done, m_count, m_tc, m_run, m_fin);
      end
    end
    reset = 1'b0; load = 1'b0; start = 1'b0; enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_saturate();
    test_load_priority();
    test_oneshot_down();
    test_reset_in_run();
    test_overflow_guard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
